// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit: FSM states, one-hot access sizes
// and exception cause codes reserved for the CSR block.
package lsu_ctrl_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    ERR,
    DRAIN
  } lsu_state_e;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0010;
  localparam logic [3:0] SZ_W = 4'b0100;
  localparam logic [3:0] SZ_D = 4'b1000;

  typedef enum logic [3:0] {
    CAUSE_LOAD_MISALIGN  = 4'd4,
    CAUSE_LOAD_FAULT     = 4'd5,
    CAUSE_STORE_MISALIGN = 4'd6,
    CAUSE_STORE_FAULT    = 4'd7
  } lsu_cause_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory port of the LSU: req/gnt request phase, rvalid response phase.
interface lsu_ctrl_if #(
  parameter int XLEN = lsu_ctrl_pkg::XLEN
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [XLEN-1:0]   mem_adr_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;
  logic              mem_err_i;

  modport master (
    output mem_req_o, mem_we_o, mem_adr_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_adr_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/lsu_ctrl_align.sv
// Combinational lane logic: byte enables, store-data shift and misalignment
// for the request side; load extraction and sign/zero extension for the response.
module lsu_ctrl_align import lsu_ctrl_pkg::*; #(
  parameter int  XLEN    = lsu_ctrl_pkg::XLEN,
  parameter int  NB_SIZE = $clog2(XLEN/8) + 1,
  localparam int LANE_W  = $clog2(XLEN/8),
  localparam int NBYTE   = XLEN/8
) (
  input  logic [LANE_W-1:0]  req_off,
  input  logic [NB_SIZE-1:0] req_size,
  input  logic [XLEN-1:0]    req_wdata,
  output logic [NBYTE-1:0]   req_be,
  output logic [XLEN-1:0]    req_wdata_lane,
  output logic               req_misalign,
  input  logic [LANE_W-1:0]  rsp_off,
  input  logic [NB_SIZE-1:0] rsp_size,
  input  logic               rsp_unsign,
  input  logic [XLEN-1:0]    rsp_rdata,
  output logic [XLEN-1:0]    rsp_data
);

  logic [XLEN-1:0]    rdata_shift;
  logic [NBYTE-1:0]   be_sz  [NB_SIZE];
  logic [XLEN-1:0]    ext_sz [NB_SIZE];
  logic [NB_SIZE-1:0] mis_sz;

  assign rdata_shift    = rsp_rdata >> {rsp_off, 3'b000};
  assign req_wdata_lane = req_wdata << {req_off, 3'b000};

  for (genvar gi = 0; gi < NB_SIZE; gi++) begin : g_size
    localparam int FW = 8 << gi;
    localparam logic [NBYTE-1:0] BE_BASE = NBYTE'((1 << (1 << gi)) - 1);

    assign be_sz[gi] = BE_BASE << req_off;

    if (gi == 0) begin : g_byte
      assign mis_sz[gi] = 1'b0;
    end else begin : g_wide
      assign mis_sz[gi] = |req_off[gi-1:0];
    end

    // Sign comes from the top bit of the selected field, wherever the lane was.
    if (FW >= XLEN) begin : g_full
      assign ext_sz[gi] = rdata_shift;
    end else begin : g_part
      assign ext_sz[gi] = {{(XLEN-FW){~rsp_unsign & rdata_shift[FW-1]}}, rdata_shift[FW-1:0]};
    end
  end

  always_comb begin
    req_be   = '0;
    rsp_data = '0;
    for (int k = 0; k < NB_SIZE; k++) begin
      if (req_size[k]) req_be = be_sz[k];
      if (rsp_size[k]) rsp_data = ext_sz[k];
    end
  end

  // A size code that is not one-hot cannot be issued, so it reports as misaligned.
  assign req_misalign = !$onehot(req_size) || (|(mis_sz & req_size));

endmodule

// File: rtl/lsu_ctrl.sv
// Sequential load/store unit: one outstanding access on a req/gnt/rvalid
// memory port, stalling execute until the response is delivered to writeback.
module lsu_ctrl import lsu_ctrl_pkg::*; #(
  parameter int  XLEN    = lsu_ctrl_pkg::XLEN,
  parameter int  NB_SIZE = $clog2(XLEN/8) + 1,
  localparam int LANE_W  = $clog2(XLEN/8),
  localparam int NBYTE   = XLEN/8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lsu_en_i,
  input  logic               is_store_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [XLEN-1:0]    immediat_i,
  input  logic [NB_SIZE-1:0] access_size_i,
  input  logic               unsign_extension_i,
  input  logic               flush_i,
  output logic               lsu_ready_o,
  output logic               lsu_valid_o,
  output logic [XLEN-1:0]    lsu_data_o,
  output logic               misalign_o,
  output logic               access_fault_o,
  lsu_ctrl_if.master         mem
);

  lsu_state_e         state_reg, state_next;
  logic [XLEN-1:0]    adr_next, adr_reg, wdata_reg, rdata_reg;
  logic [XLEN-1:0]    wdata_lane, load_data;
  logic [NBYTE-1:0]   be_reg, be_lane;
  logic [NB_SIZE-1:0] size_reg;
  logic               unsign_reg, store_reg, err_reg;
  logic               misalign, accept, in_req;

  assign adr_next    = rs1_data_i + immediat_i;
  assign lsu_ready_o = (state_reg == IDLE);
  assign accept      = lsu_en_i && lsu_ready_o && !flush_i;

  lsu_ctrl_align #(.XLEN(XLEN), .NB_SIZE(NB_SIZE)) u_align (
    .req_off        (adr_next[LANE_W-1:0]),
    .req_size       (access_size_i),
    .req_wdata      (rs2_data_i),
    .req_be         (be_lane),
    .req_wdata_lane (wdata_lane),
    .req_misalign   (misalign),
    .rsp_off        (adr_reg[LANE_W-1:0]),
    .rsp_size       (size_reg),
    .rsp_unsign     (unsign_reg),
    .rsp_rdata      (rdata_reg),
    .rsp_data       (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      adr_reg    <= '0;
      wdata_reg  <= '0;
      be_reg     <= '0;
      size_reg   <= '0;
      unsign_reg <= 1'b0;
      store_reg  <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        adr_reg    <= adr_next;
        wdata_reg  <= wdata_lane;
        be_reg     <= be_lane;
        size_reg   <= access_size_i;
        unsign_reg <= unsign_extension_i;
        store_reg  <= is_store_i;
      end
      if (state_reg == WAIT && mem.mem_rvalid_i) begin
        rdata_reg <= mem.mem_rdata_i;
        err_reg   <= mem.mem_err_i;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    lsu_valid_o    = 1'b0;
    misalign_o     = 1'b0;
    access_fault_o = 1'b0;
    lsu_data_o     = '0;
    unique case (state_reg)
      IDLE:  if (accept) state_next = misalign ? ERR : REQ;
      REQ: begin
        // A response in the grant cycle belongs to nothing; only gnt moves us on.
        if (flush_i)            state_next = IDLE;
        else if (mem.mem_gnt_i) state_next = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid_i) state_next = flush_i ? IDLE : RESP;
        else if (flush_i)     state_next = DRAIN;
      end
      RESP: begin
        lsu_valid_o    = !flush_i;
        access_fault_o = lsu_valid_o && err_reg;
        lsu_data_o     = (lsu_valid_o && !err_reg && !store_reg) ? load_data : '0;
        state_next     = IDLE;
      end
      ERR: begin
        lsu_valid_o = !flush_i;
        misalign_o  = lsu_valid_o;
        state_next  = IDLE;
      end
      DRAIN: if (mem.mem_rvalid_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_req          = (state_reg == REQ);
  assign mem.mem_req_o   = in_req;
  assign mem.mem_we_o    = in_req && store_reg;
  assign mem.mem_adr_o   = in_req ? {adr_reg[XLEN-1:LANE_W], {LANE_W{1'b0}}} : '0;
  assign mem.mem_be_o    = in_req ? be_reg : '0;
  assign mem.mem_wdata_o = in_req ? wdata_reg : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 32-bit and a 64-bit instance driven with
// hand-computed load/store/misalign/flush/fault/reset cases.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst32, rst64;
  logic        en32, en64;
  logic        is_store, unsign, flush;
  logic [63:0] rs1, rs2, imm;
  logic [3:0]  size;

  logic        ready32, valid32, mis32, fault32;
  logic [31:0] data32;
  logic        ready64, valid64, mis64, fault64;
  logic [63:0] data64;

  int checks = 0;
  int errors = 0;

  lsu_ctrl_if #(.XLEN(32)) m32 ();
  lsu_ctrl_if #(.XLEN(64)) m64 ();

  lsu_ctrl #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(rst32), .lsu_en_i(en32), .is_store_i(is_store),
    .rs1_data_i(rs1[31:0]), .rs2_data_i(rs2[31:0]), .immediat_i(imm[31:0]),
    .access_size_i(size[2:0]), .unsign_extension_i(unsign), .flush_i(flush),
    .lsu_ready_o(ready32), .lsu_valid_o(valid32), .lsu_data_o(data32),
    .misalign_o(mis32), .access_fault_o(fault32), .mem(m32)
  );

  lsu_ctrl #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(rst64), .lsu_en_i(en64), .is_store_i(is_store),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .immediat_i(imm),
    .access_size_i(size), .unsign_extension_i(unsign), .flush_i(flush),
    .lsu_ready_o(ready64), .lsu_valid_o(valid64), .lsu_data_o(data64),
    .misalign_o(mis64), .access_fault_o(fault64), .mem(m64)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end else begin
      $display("ok   %s obs=%h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access32(input string tag, input logic st, input logic [31:0] a_rs1,
                          input logic [31:0] a_imm, input logic [31:0] a_rs2,
                          input logic [2:0] sz, input logic uns, input logic [31:0] rdata,
                          input int gnt_delay, input logic [31:0] exp_adr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_data);
    is_store = st; rs1 = {32'h0, a_rs1}; imm = {32'h0, a_imm}; rs2 = {32'h0, a_rs2};
    size = {1'b0, sz}; unsign = uns; en32 = 1'b1;
    check({tag, ".ready"}, ready32, 1);
    tick();
    en32 = 1'b0;
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i == gnt_delay) m32.mem_gnt_i = 1'b1;
      check({tag, ".req"}, m32.mem_req_o, 1);
      check({tag, ".we"}, m32.mem_we_o, st);
      check({tag, ".adr"}, m32.mem_adr_o, exp_adr);
      check({tag, ".be"}, m32.mem_be_o, exp_be);
      check({tag, ".wdata"}, m32.mem_wdata_o, exp_wdata);
      tick();
    end
    m32.mem_gnt_i = 1'b0;
    m32.mem_rvalid_i = 1'b1;
    m32.mem_rdata_i = rdata;
    check({tag, ".wait_req"}, m32.mem_req_o, 0);
    check({tag, ".wait_valid"}, valid32, 0);
    tick();
    m32.mem_rvalid_i = 1'b0;
    m32.mem_rdata_i = '0;
    check({tag, ".valid"}, valid32, 1);
    check({tag, ".data"}, data32, exp_data);
    check({tag, ".fault"}, fault32, 0);
    check({tag, ".mis"}, mis32, 0);
    tick();
    check({tag, ".done_valid"}, valid32, 0);
    check({tag, ".done_ready"}, ready32, 1);
  endtask

  task automatic misalign32(input string tag, input logic [31:0] a_rs1,
                            input logic [31:0] a_imm, input logic [2:0] sz);
    is_store = 1'b0; rs1 = {32'h0, a_rs1}; imm = {32'h0, a_imm}; size = {1'b0, sz};
    unsign = 1'b0; en32 = 1'b1;
    tick();
    en32 = 1'b0;
    check({tag, ".req"}, m32.mem_req_o, 0);
    check({tag, ".valid"}, valid32, 1);
    check({tag, ".mis"}, mis32, 1);
    check({tag, ".data"}, data32, 0);
    tick();
    check({tag, ".done_valid"}, valid32, 0);
    check({tag, ".done_ready"}, ready32, 1);
  endtask

  initial begin
    rst32 = 1'b1; rst64 = 1'b1; en32 = 1'b0; en64 = 1'b0;
    is_store = 1'b0; unsign = 1'b0; flush = 1'b0;
    rs1 = '0; rs2 = '0; imm = '0; size = '0;
    m32.mem_gnt_i = 1'b0; m32.mem_rvalid_i = 1'b0; m32.mem_rdata_i = '0; m32.mem_err_i = 1'b0;
    m64.mem_gnt_i = 1'b0; m64.mem_rvalid_i = 1'b0; m64.mem_rdata_i = '0; m64.mem_err_i = 1'b0;
    tick(); tick();
    check("rst.ready32", ready32, 1);
    check("rst.valid32", valid32, 0);
    check("rst.req32", m32.mem_req_o, 0);
    check("rst.data32", data32, 0);
    check("rst.ready64", ready64, 1);
    check("rst.req64", m64.mem_req_o, 0);
    rst32 = 1'b0; rst64 = 1'b0;
    tick();

    access32("lb",  0, 32'h1000, 32'h3, 32'h0, 3'b001, 0, 32'h80FF_0000, 0,
             32'h1000, 4'h8, 32'h0, 32'hFFFF_FF80);
    access32("lbu", 0, 32'h1000, 32'h3, 32'h0, 3'b001, 1, 32'h80FF_0000, 0,
             32'h1000, 4'h8, 32'h0, 32'h0000_0080);
    access32("lh",  0, 32'h1000, 32'h2, 32'h0, 3'b010, 0, 32'h1234_F00D, 0,
             32'h1000, 4'hC, 32'h0, 32'h0000_1234);
    access32("lhs", 0, 32'h40, 32'h0, 32'h0, 3'b010, 0, 32'h0000_8001, 0,
             32'h40, 4'h3, 32'h0, 32'hFFFF_8001);
    access32("sw",  1, 32'h100, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 3'b100, 0, 32'h0, 3,
             32'hFC, 4'hF, 32'hDEAD_BEEF, 32'h0);
    access32("sb",  1, 32'h200, 32'h1, 32'h1234_56AB, 3'b001, 0, 32'h0, 1,
             32'h200, 4'h2, 32'h3456_AB00, 32'h0);

    misalign32("lw_mis", 32'h2000, 32'h2, 3'b100);
    misalign32("bad_size", 32'h0, 32'h0, 3'b011);

    // flush together with enable: nothing accepted
    is_store = 1'b0; rs1 = 64'h3000; imm = '0; size = 4'b0100; en32 = 1'b1; flush = 1'b1;
    tick();
    en32 = 1'b0; flush = 1'b0;
    check("fl_en.ready", ready32, 1);
    check("fl_en.req", m32.mem_req_o, 0);

    // flush while requesting
    en32 = 1'b1;
    tick();
    en32 = 1'b0;
    check("fl_req.req", m32.mem_req_o, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_req.req_drop", m32.mem_req_o, 0);
    check("fl_req.ready", ready32, 1);

    // flush while waiting: response drained, never reported
    en32 = 1'b1;
    tick();
    en32 = 1'b0;
    m32.mem_gnt_i = 1'b1;
    tick();
    m32.mem_gnt_i = 1'b0;
    flush = 1'b1;
    check("fl_wait.valid", valid32, 0);
    tick();
    flush = 1'b0;
    check("fl_wait.drain_ready", ready32, 0);
    tick();
    m32.mem_rvalid_i = 1'b1; m32.mem_rdata_i = 32'hCAFE_F00D;
    check("fl_wait.rv_ready", ready32, 0);
    check("fl_wait.rv_valid", valid32, 0);
    tick();
    m32.mem_rvalid_i = 1'b0;
    check("fl_wait.ready", ready32, 1);
    check("fl_wait.no_valid", valid32, 0);

    // 64-bit LW at lane 4, sign taken from bit 63 of the word
    is_store = 1'b0; rs1 = '0; imm = 64'hC; size = 4'b0100; unsign = 1'b0; en64 = 1'b1;
    tick();
    en64 = 1'b0;
    check("lw64.adr", m64.mem_adr_o, 64'h8);
    check("lw64.be", m64.mem_be_o, 8'hF0);
    m64.mem_gnt_i = 1'b1;
    tick();
    m64.mem_gnt_i = 1'b0;
    m64.mem_rvalid_i = 1'b1; m64.mem_rdata_i = 64'h8000_0000_1111_2222;
    tick();
    m64.mem_rvalid_i = 1'b0;
    check("lw64.valid", valid64, 1);
    check("lw64.data", data64, 64'hFFFF_FFFF_8000_0000);

    // 64-bit LD with bus error
    tick();
    rs1 = '0; imm = 64'h8; size = 4'b1000; en64 = 1'b1;
    tick();
    en64 = 1'b0;
    check("ld64.adr", m64.mem_adr_o, 64'h8);
    check("ld64.be", m64.mem_be_o, 8'hFF);
    m64.mem_gnt_i = 1'b1;
    tick();
    m64.mem_gnt_i = 1'b0;
    m64.mem_rvalid_i = 1'b1; m64.mem_err_i = 1'b1; m64.mem_rdata_i = 64'h1122_3344_5566_7788;
    tick();
    m64.mem_rvalid_i = 1'b0; m64.mem_err_i = 1'b0;
    check("ld64.valid", valid64, 1);
    check("ld64.fault", fault64, 1);
    check("ld64.data", data64, 0);
    check("ld64.mis", mis64, 0);

    // reset during REQ drops the request without a clock edge
    tick();
    imm = 64'h10; en64 = 1'b1;
    tick();
    en64 = 1'b0;
    check("rst_req.req", m64.mem_req_o, 1);
    #1 rst64 = 1'b1;
    #1;
    check("rst_req.req_drop", m64.mem_req_o, 0);
    check("rst_req.ready", ready64, 1);
    tick();
    rst64 = 1'b0;
    m64.mem_rvalid_i = 1'b1; m64.mem_rdata_i = 64'hFFFF;
    tick();
    m64.mem_rvalid_i = 1'b0;
    check("rst_req.stray_valid", valid64, 0);
    check("rst_req.idle_ready", ready64, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
